// File: rtl/lsu_if.sv
// Handshaked data-memory bus between the load/store unit (master) and memory (slave).
// Fields are registered by the master and held stable while req is high.
interface lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: bridges a single-cycle core's memory signals to a handshaked
// word bus, aligning stores, extending loads and stalling while a transfer is open.
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        fault,
    lsu_if.master       bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          fault_q, fault_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;

    logic          acc;
    logic          aligned;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    // Size decode on funct3[1:0]: 00 byte, 01 half, anything else is a word.
    always_comb begin
        acc = mem_read | mem_write;
        case (funct3[1:0])
            2'b00: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr[0];
                be_new    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                aligned   = (addr[1:0] == 2'b00);
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Load extraction uses the size/sign and byte offset latched at request time.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus.rdata[7:0];
            2'd1:    ld_byte = bus.rdata[15:8];
            2'd2:    ld_byte = bus.rdata[23:16];
            default: ld_byte = bus.rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ld_ext = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
            default: ld_ext = bus.rdata;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc && aligned) begin
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // An ack in the timeout cycle still completes the access normally.
                if (bus.ack) begin
                    req_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : ld_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    rdata_d = 32'd0;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; every register, including the
    // bus fields, resets so nothing is X after an abandoned transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        stall    = ((state_q == S_IDLE) && acc && aligned) || (state_q == S_BUSY);
        misalign = (state_q == S_IDLE) && acc && !aligned;
        rdata    = (state_q == S_DONE) ? rdata_q : 32'd0;
        fault    = fault_q;
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected transfers are queued when an access is issued
// and compared when the unit reaches its completion cycle.
module tb_lsu;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          busy;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        fault;

    int total = 0;
    int bad = 0;

    lsu_if bus_if ();

    lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .misalign (misalign),
        .fault    (fault),
        .bus      (bus_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic flt, input int busy);
        exp_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd;
        e.rdata = rd; e.fault = flt; e.busy = busy;
        return e;
    endfunction

    // ack_cyc: BUSY cycle (1-based) during which ack is presented; 0 = never.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_cyc, input logic [31:0] word, input exp_t e);
        exp_t got;
        int   busy;
        bit   done;
        sb.push_back(e);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check({tag, ".t0_stall"}, stall, 1);
        check({tag, ".t0_req"}, bus_if.req, 0);
        busy = 0;
        done = 0;
        for (int i = 0; i < TIMEOUT + 4 && !done; i++) begin
            @(posedge clk); #1;
            bus_if.ack = 1'b0;
            if (stall) begin
                busy++;
                got = sb[0];
                check({tag, ".req"}, bus_if.req, 1);
                check({tag, ".we"}, bus_if.we, got.we);
                check({tag, ".addr"}, bus_if.addr, got.addr);
                check({tag, ".be"}, bus_if.be, got.be);
                check({tag, ".wdata"}, bus_if.wdata, got.wdata);
                if (busy == ack_cyc) begin
                    bus_if.ack = 1'b1;
                    bus_if.rdata = word;
                end
            end else begin
                done = 1;
                got = sb.pop_front();
                if (!got.we) check({tag, ".rdata"}, rdata, got.rdata);
                check({tag, ".fault"}, fault, got.fault);
                check({tag, ".done_req"}, bus_if.req, 0);
                check({tag, ".busy_cycles"}, busy, got.busy);
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
        check({tag, ".completed"}, done, 1);
        if (!done) begin
            void'(sb.pop_front());
            mem_read = 1'b0; mem_write = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, ".after_fault"}, fault, 0);
        check({tag, ".after_stall"}, stall, 0);
        check({tag, ".after_rdata"}, rdata, 0);
    endtask

    task automatic misaligned(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'h1234_5678;
        @(negedge clk);
        check({tag, ".misalign"}, misalign, 1);
        check({tag, ".stall"}, stall, 0);
        check({tag, ".rdata"}, rdata, 0);
        check({tag, ".req"}, bus_if.req, 0);
        @(posedge clk); #1;
        check({tag, ".req_next"}, bus_if.req, 0);
        check({tag, ".misalign_held"}, misalign, 1);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        check({tag, ".misalign_clear"}, misalign, 0);
    endtask

    initial begin
        bus_if.ack = 1'b0;
        bus_if.rdata = 32'd0;

        #12;
        check("reset.req", bus_if.req, 0);
        check("reset.we", bus_if.we, 0);
        check("reset.addr", bus_if.addr, 0);
        check("reset.be", bus_if.be, 0);
        check("reset.wdata", bus_if.wdata, 0);
        check("reset.rdata", rdata, 0);
        check("reset.fault", fault, 0);
        check("reset.stall", stall, 0);
        @(negedge clk);
        reset = 1'b1;

        access("sw", 0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'd0,
               mk(1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'd0, 0, 1));
        access("sb", 0, 1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'd0,
               mk(1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'd0, 0, 1));
        access("sh", 0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 3, 32'd0,
               mk(1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'd0, 0, 3));
        access("lb", 1, 0, 3'b000, 32'h0000_0202, 32'd0, 2, 32'h12F4_5678,
               mk(0, 32'h0000_0200, 4'b0100, 32'd0, 32'hFFFF_FFF4, 0, 2));
        access("lbu", 1, 0, 3'b100, 32'h0000_0202, 32'd0, 1, 32'h12F4_5678,
               mk(0, 32'h0000_0200, 4'b0100, 32'd0, 32'h0000_00F4, 0, 1));
        access("lh", 1, 0, 3'b001, 32'h0000_0202, 32'd0, 1, 32'h12F4_5678,
               mk(0, 32'h0000_0200, 4'b1100, 32'd0, 32'h0000_12F4, 0, 1));
        access("lh_lo", 1, 0, 3'b001, 32'h0000_0200, 32'd0, 1, 32'h0000_8001,
               mk(0, 32'h0000_0200, 4'b0011, 32'd0, 32'hFFFF_8001, 0, 1));
        access("lhu_lo", 1, 0, 3'b101, 32'h0000_0200, 32'd0, 2, 32'h0000_8001,
               mk(0, 32'h0000_0200, 4'b0011, 32'd0, 32'h0000_8001, 0, 2));
        access("lw", 1, 0, 3'b010, 32'h0000_0304, 32'd0, 3, 32'hCAFE_F00D,
               mk(0, 32'h0000_0304, 4'b1111, 32'd0, 32'hCAFE_F00D, 0, 3));
        access("rw_both", 1, 1, 3'b010, 32'h0000_0400, 32'h0BAD_F00D, 1, 32'd0,
               mk(1, 32'h0000_0400, 4'b1111, 32'h0BAD_F00D, 32'd0, 0, 1));

        misaligned("lw_mis", 1, 0, 3'b010, 32'h0000_0301);
        misaligned("sh_mis", 0, 1, 3'b001, 32'h0000_0101);

        access("lw_timeout", 1, 0, 3'b010, 32'h0000_0500, 32'd0, 0, 32'd0,
               mk(0, 32'h0000_0500, 4'b1111, 32'd0, 32'd0, 1, TIMEOUT));
        access("lw_ack_last", 1, 0, 3'b010, 32'h0000_0500, 32'd0, TIMEOUT, 32'h7654_3210,
               mk(0, 32'h0000_0500, 4'b1111, 32'd0, 32'h7654_3210, 0, TIMEOUT));

        // Non-memory instruction: one cycle, no stall, no request.
        @(posedge clk); #1;
        addr = 32'h0000_0600;
        #1;
        check("nop.stall", stall, 0);
        check("nop.misalign", misalign, 0);
        @(posedge clk); #1;
        check("nop.req", bus_if.req, 0);

        // Reset asserted while a transfer is outstanding.
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0700; wdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        check("rst.req_busy", bus_if.req, 1);
        check("rst.wdata_busy", bus_if.wdata, 32'h55AA_55AA);
        mem_read = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst.req_async", bus_if.req, 0);
        check("rst.addr", bus_if.addr, 0);
        check("rst.wdata", bus_if.wdata, 0);
        check("rst.be", bus_if.be, 0);
        check("rst.stall", stall, 0);
        check("rst.rdata", rdata, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        bus_if.ack = 1'b1;
        bus_if.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_if.ack = 1'b0;
        check("stray.stall", stall, 0);
        check("stray.req", bus_if.req, 0);
        check("stray.rdata", rdata, 0);
        check("stray.fault", fault, 0);
        @(posedge clk); #1;
        check("stray.rdata_next", rdata, 0);

        access("post_rst_lb", 1, 0, 3'b000, 32'h0000_0801, 32'd0, 1, 32'h0000_7F00,
               mk(0, 32'h0000_0800, 4'b0010, 32'd0, 32'h0000_007F, 0, 1));

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the single-cycle core's memory-access signals (ALU result as address, register read data as store data, load result returned as read data) and a handshaked data-memory bus. It aligns and byte-enables stores and extracts and extends loads. It stalls the core while a bus transaction is outstanding and flags misaligned and timed-out accesses. Non-memory instructions pass through with no added cycles.

## Interface

- TIMEOUT, 16: max cycles in BUSY without `bus_ack` before the access is aborted; must be ≥2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  current instruction is a load.
- `mem_write`  in  1  current instruction is a store; wins if both are high.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes behave as W.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned.
- `rdata`  out  32  load result, extended; valid in DONE, 0 otherwise.
- `stall`  out  1  core must hold PC and suppress register write.
- `misalign`  out  1  misaligned access detected; no bus traffic.
- `fault`  out  1  bus timeout; high for the DONE cycle only.
- `bus_req`  out  1  registered request; held until ack or timeout.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`, registered.
- `bus_be`  out  4  byte enables, registered.
- `bus_wdata`  out  32  lane-replicated store data, registered.
- `bus_rdata`  in  32  word read data, valid with `bus_ack`.
- `bus_ack`  in  1  one-cycle completion strobe.

## Operation

- Access: `acc = mem_read | mem_write`.
- Alignment: H/HU needs `addr[0]=0`; W needs `addr[1:0]=00`; B/BU always aligned.
- States:
  - IDLE, with aligned `acc`: latch `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `funct3`, and `addr[1:0]`; set `bus_req`; go to BUSY.
  - IDLE, with misaligned `acc`: `misalign=1` combinationally, `stall=0`, `rdata=0`, no request; stay in IDLE.
  - BUSY, on `bus_ack`: clear `bus_req`; on a read, register the extended `rdata`; go to DONE. Ack is accepted in the first BUSY cycle.
  - BUSY, timeout: on the TIMEOUT-th BUSY cycle with no ack, clear `bus_req`, set `rdata=0`, set `fault`, go to DONE. Ack in the same cycle as timeout wins; no fault.
  - DONE: `stall=0`, so the core retires the held instruction and samples `rdata`. Unconditionally return to IDLE, even if `acc` is still high.
- `stall = (IDLE & acc & aligned) | BUSY`.
- Store lanes:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{wdata[15:0]}}`.
  - SW: `be = 1111`, `wdata` unchanged.
- Load extraction: select the byte by latched `addr[1:0]`, or the halfword by `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
  - `bus_be` on reads is the same mask as for stores (informational).
- `bus_ack` outside BUSY is ignored.
- Timeout counter clears on entry to BUSY.

## Timing

- Reset (async assert, sync release):
  - State IDLE; `bus_req`, `bus_we`, `fault` = 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `rdata` = 0; counter = 0.
- Reset mid-BUSY drops `bus_req` immediately; the transaction is abandoned and a late ack is ignored.
- Zero-wait access with ack in the first BUSY cycle:
  - Request cycle T0: IDLE, `stall=1`.
  - T1: BUSY, `bus_req=1`, ack sampled.
  - T2: DONE, `stall=0`.
  - Total 3 cycles; each ack wait cycle adds one.
- Bus fields are stable for the whole time `bus_req=1`.
- Non-access and misaligned instructions take 1 cycle with no stall.
- Back-to-back accesses: DONE→IDLE, then the next access starts its own T0; no overlap.

## Test plan

- SW `addr=0x100`, `wdata=0xDEADBEEF`, ack on first BUSY cycle:
  - `bus_addr=0x100`, `be=1111`, `wdata=0xDEADBEEF`, `we=1`.
  - `stall` high for 2 cycles, low in DONE.
- SB `addr=0x103`, `wdata=0x000000A5`: `be=1000`, `bus_wdata=0xA5A5A5A5`.
- LB `addr=0x202`, `bus_rdata=0x12F45678`: `rdata=0xFFFFFFF4`.
  - Same with LBU: `0x000000F4`.
  - LH `addr=0x202`: `0x000012F4`.
- LW `addr=0x301`: `misalign=1`, `stall=0`, `bus_req` never rises, `rdata=0`.
- LW with ack withheld, TIMEOUT=16:
  - `bus_req` high for 16 cycles, then DONE with `fault=1`, `rdata=0`.
  - Repeat with ack on cycle 16: no fault, data returned.
- Assert `reset` low during BUSY: `bus_req` falls asynchronously, all outputs reset; a subsequent stray `bus_ack` causes no state change.
